// File: rtl/hamming_secded_dec_pkg.sv
// Shared helpers for the SECDED decoder: code geometry and word classification.
// Pure constants and functions, no logic of its own.
// Not applicable (no handshake).
package hamming_pkg;

    // Outcome of decoding one codeword
    typedef enum logic [1:0] {
        CLEAN  = 2'd0,
        CORR   = 2'd1,
        UNCORR = 2'd2
    } cls_e;

    // Number of Hamming parity bits: smallest r with 2^r >= data_w + r + 1
    function automatic int calc_r(input int data_w);
        int r;
        r = 1;
        for (int k = 0; k < 8; k++) begin
            if ((1 << r) < data_w + r + 1) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int p);
        return (p > 0) && ((p & (p - 1)) == 0);
    endfunction

    // Hamming position of data bit i: the i-th non-power-of-two position from 1 upward
    function automatic int data_pos(input int i);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 1; p < 128; p++) begin
            if (!is_pow2(p)) begin
                if (cnt == i && pos == 0) begin
                    pos = p;
                end
                cnt = cnt + 1;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_secded_dec_if.sv
// Handshake bundle between the receive port, the SECDED decoder and its consumer.
// Wires only, no latency.
// Carries both valid/ready pairs; the decoder is the slave side.
interface hamming_secded_dec_if #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16
) ();
    import hamming_pkg::*;

    localparam int R = calc_r(DATA_W);
    localparam int N = DATA_W + R + 1;

    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      in_code;
    logic              correct_en;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_corrected;
    logic              out_uncorr;
    logic [R-1:0]      out_syndrome;
    logic              clr_cnt;
    logic [CNT_W-1:0]  cnt_corr;
    logic [CNT_W-1:0]  cnt_uncorr;

    modport master (
        output in_valid, in_code, correct_en, out_ready, clr_cnt,
        input  in_ready, out_valid, out_data, out_corrected, out_uncorr,
               out_syndrome, cnt_corr, cnt_uncorr
    );

    modport slave (
        input  in_valid, in_code, correct_en, out_ready, clr_cnt,
        output in_ready, out_valid, out_data, out_corrected, out_uncorr,
               out_syndrome, cnt_corr, cnt_uncorr
    );

endinterface

// File: rtl/hamming_secded_dec_syndrome.sv
// Hamming syndrome and overall parity of a codeword.
// Purely combinational, zero latency.
// No handshake; evaluated on whatever sits on the input.
module hamming_syndrome #(
    parameter int N = 8,
    parameter int R = 3
) (
    input  logic [N-1:0] code,
    output logic [R-1:0] syn,
    output logic         par
);

    // Syndrome is the XOR of every set position index; bit 0 only feeds overall parity
    always_comb begin
        syn = '0;
        for (int p = 1; p < N; p++) begin
            if (code[p]) begin
                syn = syn ^ R'(p);
            end
        end
        par = ^code;
    end

endmodule

// File: rtl/hamming_secded_dec.sv
// Pipelined Hamming SECDED decoder with detect-only mode and saturating error counters.
// Two register stages: out_valid follows an accepted codeword by 2 cycles, 1 word/cycle.
// Stalls propagate backwards: in_ready drops only when both stages hold words and out_ready is low.
module hamming_secded_dec #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    hamming_secded_dec_if.slave bus
);
    import hamming_pkg::*;

    localparam int R = calc_r(DATA_W);
    localparam int N = DATA_W + R + 1;

    // Syndrome of the word on the input port
    logic [R-1:0] syn_c;
    logic         par_c;

    // Stage 1 state
    logic              s1_valid_q, s1_valid_d;
    logic [N-1:0]      s1_code_q,  s1_code_d;
    logic [R-1:0]      s1_syn_q,   s1_syn_d;
    logic              s1_par_q,   s1_par_d;
    logic              s1_cen_q,   s1_cen_d;

    // Stage 2 state (drives the output port)
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] data_q,     data_d;
    logic              corr_q,     corr_d;
    logic              uncorr_q,   uncorr_d;
    logic [R-1:0]      syn_q,      syn_d;

    // Error counters
    logic [CNT_W-1:0]  cnt_corr_q,   cnt_corr_d;
    logic [CNT_W-1:0]  cnt_uncorr_q, cnt_uncorr_d;

    logic              s1_load;
    logic              s2_load;
    logic              out_fire;
    cls_e              cls_c;
    logic [N-1:0]      fixed_c;
    logic [DATA_W-1:0] data_c;

    hamming_syndrome #(.N(N), .R(R)) u_syndrome (
        .code (bus.in_code),
        .syn  (syn_c),
        .par  (par_c)
    );

    assign s2_load  = !s2_valid_q || bus.out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign out_fire = s2_valid_q && bus.out_ready;

    assign bus.in_ready      = s1_load;
    assign bus.out_valid     = s2_valid_q;
    assign bus.out_data      = data_q;
    assign bus.out_corrected = corr_q;
    assign bus.out_uncorr    = uncorr_q;
    assign bus.out_syndrome  = syn_q;
    assign bus.cnt_corr      = cnt_corr_q;
    assign bus.cnt_uncorr    = cnt_uncorr_q;

    // Stage 1: capture codeword, syndrome, parity and the per-word correct_en
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_code_d  = s1_code_q;
        s1_syn_d   = s1_syn_q;
        s1_par_d   = s1_par_q;
        s1_cen_d   = s1_cen_q;
        if (s1_load) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_code_d = bus.in_code;
                s1_syn_d  = syn_c;
                s1_par_d  = par_c;
                s1_cen_d  = bus.correct_en;
            end
        end
    end

    // Classify the stage-1 word; a syndrome beyond the codeword only occurs in shortened codes
    always_comb begin
        cls_c = CLEAN;
        if (s1_par_q) begin
            if (int'(s1_syn_q) <= N - 1) begin
                cls_c = CORR;
            end else begin
                cls_c = UNCORR;
            end
        end else if (s1_syn_q != '0) begin
            cls_c = UNCORR;
        end
    end

    // Repair the flagged position (if enabled) and pull data bits out of their positions
    always_comb begin
        fixed_c = s1_code_q;
        if (cls_c == CORR && s1_cen_q) begin
            for (int p = 1; p < N; p++) begin
                if (s1_syn_q == R'(p)) begin
                    fixed_c[p] = ~s1_code_q[p];
                end
            end
        end
        data_c = '0;
        for (int i = 0; i < DATA_W; i++) begin
            data_c[i] = fixed_c[data_pos(i)];
        end
    end

    // Stage 2: hold the result until the consumer takes it
    always_comb begin
        s2_valid_d = s2_valid_q;
        data_d     = data_q;
        corr_d     = corr_q;
        uncorr_d   = uncorr_q;
        syn_d      = syn_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                data_d   = data_c;
                corr_d   = (cls_c == CORR);
                uncorr_d = (cls_c == UNCORR);
                syn_d    = s1_syn_q;
            end
        end
    end

    // Count delivered flagged beats, saturating; clear has priority
    always_comb begin
        cnt_corr_d   = cnt_corr_q;
        cnt_uncorr_d = cnt_uncorr_q;
        if (bus.clr_cnt) begin
            cnt_corr_d   = '0;
            cnt_uncorr_d = '0;
        end else begin
            if (out_fire && corr_q && cnt_corr_q != '1) begin
                cnt_corr_d = cnt_corr_q + CNT_W'(1);
            end
            if (out_fire && uncorr_q && cnt_uncorr_q != '1) begin
                cnt_uncorr_d = cnt_uncorr_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset discards in-flight words and clears results and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_code_q    <= '0;
            s1_syn_q     <= '0;
            s1_par_q     <= 1'b0;
            s1_cen_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            data_q       <= '0;
            corr_q       <= 1'b0;
            uncorr_q     <= 1'b0;
            syn_q        <= '0;
            cnt_corr_q   <= '0;
            cnt_uncorr_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_code_q    <= s1_code_d;
            s1_syn_q     <= s1_syn_d;
            s1_par_q     <= s1_par_d;
            s1_cen_q     <= s1_cen_d;
            s2_valid_q   <= s2_valid_d;
            data_q       <= data_d;
            corr_q       <= corr_d;
            uncorr_q     <= uncorr_d;
            syn_q        <= syn_d;
            cnt_corr_q   <= cnt_corr_d;
            cnt_uncorr_q <= cnt_uncorr_d;
        end
    end

endmodule

// File: doc/hamming_secded_dec.md
# hamming_secded_dec

- Parametrised, pipelined Hamming SECDED decoder: single-error correction, double-error detection.
- Generalises the fixed 7-bit single-error corrector to any data width and adds an overall parity bit, valid/ready handshaking, a detect-only mode and saturating error counters.
- Sits between a link/storage receive port and the consumer on the clocked RTL side of the design.

## Interface

Parameters:

- DATA_W, default 4: data bits per word, range 1..57.
- CNT_W, default 16: width of each error counter.
- R, derived: smallest R with 2^R >= DATA_W+R+1.
- N, derived: DATA_W+R+1, the codeword width.

Ports:

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  codeword present.
- in_ready  out  1  decoder accepts the codeword this cycle.
- in_code  in  N  codeword.
- correct_en  in  1  1 = correct single errors; 0 = detect only. Sampled with each accepted word.
- out_valid  out  1  decoded word present.
- out_ready  in  1  consumer accepts.
- out_data  out  DATA_W  decoded data.
- out_corrected  out  1  a single error was found; in detect-only mode it was not repaired.
- out_uncorr  out  1  uncorrectable error detected.
- out_syndrome  out  R  Hamming syndrome.
- clr_cnt  in  1  synchronous counter clear.
- cnt_corr  out  CNT_W  beats delivered with out_corrected=1.
- cnt_uncorr  out  CNT_W  beats delivered with out_uncorr=1.

## Operation

- Codeword layout:
  - in_code[0] is the overall parity bit; even parity over all N bits.
  - in_code[p] for p = 1..N-1 is Hamming position p.
  - Parity bits sit at power-of-two positions.
  - Data bits fill the remaining positions in ascending order, data[0] first.
- Syndrome S is the XOR of every index p (1..N-1) with in_code[p]=1. P is the XOR of all N bits.
- Classification:
  - S=0, P=0: clean. Both flags 0.
  - P=1, S=0: error in the parity bit itself. out_corrected=1; data unaffected.
  - P=1, 1<=S<=N-1: single error. out_corrected=1. When correct_en=1, code[S] is inverted before data extraction.
  - P=1, S>N-1 (shortened codes only): out_uncorr=1, data raw.
  - P=0, S!=0: double error. out_uncorr=1, data raw.
- out_syndrome always carries S.
- Exactly one or neither of out_corrected and out_uncorr is set, never both.
- Counters:
  - A counter increments on each output transfer (out_valid & out_ready) whose corresponding flag is set.
  - Counters saturate at all ones.
  - clr_cnt zeroes both counters next cycle; clr_cnt wins over a simultaneous increment.

## Timing

- Two register stages:
  - S1 registers the codeword, S, P and correct_en.
  - S2 registers out_data, the flags and out_syndrome.
  - Latency from input transfer to out_valid is 2 cycles. Throughput is 1 word/cycle.
- Stall logic:
  - S2 loads when !s2_valid | out_ready.
  - S1 loads when !s1_valid | S2 loads.
  - in_ready equals the S1 load condition. The combinational path out_ready -> in_ready is permitted.
- Output stability: out_* stay stable while out_valid=1 and out_ready=0.
- Ordering: words leave in arrival order. There is no drop and no duplication.
- Reset:
  - Clears s1_valid, s2_valid, out_data, both flags, out_syndrome and both counters to 0.
  - Asserting rst_n low mid-operation discards in-flight words immediately; in_ready reads 1 after release.
- correct_en may change every cycle; each word uses the value sampled at its own acceptance.

## Structure

- Package hamming_pkg holds:
  - function calc_r(data_w) giving R;
  - function is_pow2(p);
  - function data_pos(i), the Hamming position of data bit i;
  - typedef for the classification enum {CLEAN, CORR, UNCORR}.
- Sub-module hamming_syndrome: combinational (in_code -> S, P), instantiated once in front of S1.
- The top holds the pipeline registers, correction/extraction and counters. Estimated size is about 200 lines.

## Test plan

All scenarios use DATA_W=4 (N=8) unless noted; the clean codeword for data 4'b1011 is in_code=8'hAA.

1. Clean word: in_code=8'hAA -> 2 cycles later out_data=4'b1011, both flags 0, out_syndrome=0.
2. Single error:
   - in_code=8'h8A (bit 5 flipped) -> out_data=4'b1011, out_corrected=1, out_syndrome=5.
   - Same with correct_en=0 -> out_data=4'b1001, out_corrected=1.
   - in_code=8'hAB -> out_data=4'b1011, out_corrected=1, out_syndrome=0.
3. Double error: in_code=8'hCA (bits 5 and 6 flipped) -> out_uncorr=1, out_syndrome=3, out_data=4'b1101 (raw); cnt_uncorr=1.
4. Shortened code, DATA_W=8 (N=13): all-zero word with bits 1, 4 and 8 set -> S=13, P=1 -> out_uncorr=1, out_corrected=0.
5. Backpressure:
   - Hold out_ready=0 while presenting 3 words back-to-back -> exactly 2 accepted, then in_ready=0 and outputs stable.
   - Release out_ready -> all 3 words delivered in order.
   - Reset mid-stall -> out_valid=0 and counters 0.
6. Counters, CNT_W=4: 17 consecutive single-error words -> cnt_corr=15, saturated. clr_cnt on the same cycle as another corrected transfer -> cnt_corr=0.
